fix_butterfly_r2p: RTL and testbench

Parametrised, fully pipelined radix-2 fixed-point butterfly. It is the next generation of the single-shot `fix_butterfly` and accepts one complex pair per clock. It adds:
- run-time forward/inverse twiddle selection
- per-sample divide-by-2 scaling
- DIT or DIF structure chosen at elaboration
- per-sample and sticky overflow reporting

It sits between the FFT stage memory and the twiddle ROM in the 256-point fixed-point FFT datapath.

---
 rtl/fix_butterfly_r2p.sv | 225 ++++++++++++++++++++++
 tb/tb_fix_butterfly_r2p.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_butterfly_r2p.sv
// Fully pipelined radix-2 fixed-point butterfly, DIT (MODE=0) or DIF (MODE=1), one complex pair per clock.
// Build option FIX_BF_SAT_EN: saturate out-of-range outputs; otherwise they wrap to WIDTHr bits.
module fix_butterfly_r2p #(
    parameter int WIDTHa  = 20,
    parameter int WIDTHb  = 20,
    parameter int WIDTHr  = 20,
    parameter int WIDTH_I = 11,
    parameter int WIDTH_F = WIDTHr - WIDTH_I,
    parameter int TW_F    = WIDTHb - 2,
    parameter int MODE    = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic signed [WIDTHa-1:0] x1_r,
    input  logic signed [WIDTHa-1:0] x1_i,
    input  logic signed [WIDTHa-1:0] x2_r,
    input  logic signed [WIDTHa-1:0] x2_i,
    input  logic signed [WIDTHb-1:0] cosValue,
    input  logic signed [WIDTHb-1:0] sinValue,
    input  logic                     inv,
    input  logic                     scale,
    input  logic                     ovf_clr,
    output logic signed [WIDTHr-1:0] y1_r,
    output logic signed [WIDTHr-1:0] y1_i,
    output logic signed [WIDTHr-1:0] y2_r,
    output logic signed [WIDTHr-1:0] y2_i,
    output logic                     vld_out,
    output logic                     ovf_out,
    output logic                     overflow
);

    // Multiplier operand carries one extra bit so the DIF difference x1-x2 fits.
    localparam int MA = WIDTHa + 1;
    localparam int PW = MA + WIDTHb;
    localparam int SW = PW + 1;
    localparam int RW = SW - TW_F;
    localparam int FW = ((RW > WIDTHr + 2) ? RW : WIDTHr + 2) + 1;

    localparam logic signed [SW-1:0] HALF_LSB = {{(SW-1){1'b0}}, 1'b1} << (TW_F - 1);
    localparam logic signed [FW-1:0] ONE_FW   = {{(FW-1){1'b0}}, 1'b1};
    localparam logic signed [FW-1:0] R_MAX    = {{(FW-WIDTHr+1){1'b0}}, {(WIDTHr-1){1'b1}}};
    localparam logic signed [FW-1:0] R_MIN    = {{(FW-WIDTHr+1){1'b1}}, {(WIDTHr-1){1'b0}}};

    function automatic logic signed [SW-1:0] mix(input logic signed [PW-1:0] p0,
                                                 input logic signed [PW-1:0] p1,
                                                 input logic sub);
        logic signed [SW-1:0] r;
        if (sub) r = SW'(p0) - SW'(p1);
        else     r = SW'(p0) + SW'(p1);
        return r;
    endfunction

    function automatic logic signed [RW-1:0] round_tw(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] t;
        t = v + HALF_LSB;
        return t[SW-1:TW_F];
    endfunction

    function automatic logic signed [FW-1:0] scale_fn(input logic signed [FW-1:0] v, input logic s);
        logic signed [FW-1:0] r;
        if (s) r = (v + ONE_FW) >>> 1;
        else   r = v;
        return r;
    endfunction

    function automatic logic out_of_range(input logic signed [FW-1:0] v);
        return (v > R_MAX) || (v < R_MIN);
    endfunction

    function automatic logic [WIDTHr-1:0] fit(input logic signed [FW-1:0] v);
        logic [WIDTHr-1:0] r;
`ifdef FIX_BF_SAT_EN
        if (v > R_MAX)      r = R_MAX[WIDTHr-1:0];
        else if (v < R_MIN) r = R_MIN[WIDTHr-1:0];
        else                r = v[WIDTHr-1:0];
`else
        r = v[WIDTHr-1:0];
`endif
        return r;
    endfunction

    logic signed [WIDTHa-1:0] x1r_r, x1i_r, x2r_r, x2i_r;
    logic signed [WIDTHb-1:0] cos_r, sin_r;
    logic [3:0]               vld_r, inv_r, scl_r;
    logic signed [FW-1:0]     p1r_r, p1i_r, p2r_r, p2i_r;
    logic signed [FW-1:0]     q1r_s, q1i_s, q2r_s, q2i_s;
    logic                     ovf_s, ovf_set_s;

    // S1 input registers; valid, inv and scale ride along as shift registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x1r_r <= '0; x1i_r <= '0; x2r_r <= '0; x2i_r <= '0;
            cos_r <= '0; sin_r <= '0;
            vld_r <= 4'b0000; inv_r <= 4'b0000; scl_r <= 4'b0000;
        end else begin
            x1r_r <= x1_r; x1i_r <= x1_i; x2r_r <= x2_r; x2i_r <= x2_i;
            cos_r <= cosValue; sin_r <= sinValue;
            vld_r <= {vld_r[2:0], en};
            inv_r <= {inv_r[2:0], inv};
            scl_r <= {scl_r[2:0], scale};
        end
    end

    generate
        if (MODE == 0) begin : g_dit
            logic signed [WIDTHa-1:0] a1r_r, a1i_r, b1r_r, b1i_r;
            logic signed [PW-1:0]     p_ac_r, p_bs_r, p_bc_r, p_as_r;
            logic signed [RW-1:0]     t_r_r, t_i_r;

            // S2: x2 times twiddle, four partial products
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    a1r_r <= '0; a1i_r <= '0;
                    p_ac_r <= '0; p_bs_r <= '0; p_bc_r <= '0; p_as_r <= '0;
                end else begin
                    a1r_r  <= x1r_r; a1i_r <= x1i_r;
                    p_ac_r <= PW'(x2r_r) * PW'(cos_r);
                    p_bs_r <= PW'(x2i_r) * PW'(sin_r);
                    p_bc_r <= PW'(x2i_r) * PW'(cos_r);
                    p_as_r <= PW'(x2r_r) * PW'(sin_r);
                end
            end

            // S3: combine partial products by direction and round to data scale
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    b1r_r <= '0; b1i_r <= '0; t_r_r <= '0; t_i_r <= '0;
                end else begin
                    b1r_r <= a1r_r; b1i_r <= a1i_r;
                    t_r_r <= round_tw(mix(p_ac_r, p_bs_r, inv_r[1]));
                    t_i_r <= round_tw(mix(p_bc_r, p_as_r, ~inv_r[1]));
                end
            end

            // S4: butterfly add/sub
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    p1r_r <= '0; p1i_r <= '0; p2r_r <= '0; p2i_r <= '0;
                end else begin
                    p1r_r <= FW'(b1r_r) + FW'(t_r_r);
                    p1i_r <= FW'(b1i_r) + FW'(t_i_r);
                    p2r_r <= FW'(b1r_r) - FW'(t_r_r);
                    p2i_r <= FW'(b1i_r) - FW'(t_i_r);
                end
            end
        end else begin : g_dif
            logic signed [MA-1:0]     s_r_r, s_i_r, d_r_r, d_i_r, s_r2_r, s_i2_r;
            logic signed [WIDTHb-1:0] c2_r, sn2_r;
            logic signed [PW-1:0]     p_ac_r, p_bs_r, p_bc_r, p_as_r;

            // S2: sum and difference of the pair
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s_r_r <= '0; s_i_r <= '0; d_r_r <= '0; d_i_r <= '0;
                    c2_r <= '0; sn2_r <= '0;
                end else begin
                    s_r_r <= MA'(x1r_r) + MA'(x2r_r);
                    s_i_r <= MA'(x1i_r) + MA'(x2i_r);
                    d_r_r <= MA'(x1r_r) - MA'(x2r_r);
                    d_i_r <= MA'(x1i_r) - MA'(x2i_r);
                    c2_r  <= cos_r; sn2_r <= sin_r;
                end
            end

            // S3: difference times twiddle
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s_r2_r <= '0; s_i2_r <= '0;
                    p_ac_r <= '0; p_bs_r <= '0; p_bc_r <= '0; p_as_r <= '0;
                end else begin
                    s_r2_r <= s_r_r; s_i2_r <= s_i_r;
                    p_ac_r <= PW'(d_r_r) * PW'(c2_r);
                    p_bs_r <= PW'(d_i_r) * PW'(sn2_r);
                    p_bc_r <= PW'(d_i_r) * PW'(c2_r);
                    p_as_r <= PW'(d_r_r) * PW'(sn2_r);
                end
            end

            // S4: combine partial products and round; sum passes through
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    p1r_r <= '0; p1i_r <= '0; p2r_r <= '0; p2i_r <= '0;
                end else begin
                    p1r_r <= FW'(s_r2_r);
                    p1i_r <= FW'(s_i2_r);
                    p2r_r <= FW'(round_tw(mix(p_ac_r, p_bs_r, inv_r[2])));
                    p2i_r <= FW'(round_tw(mix(p_bc_r, p_as_r, ~inv_r[2])));
                end
            end
        end
    endgenerate

    assign q1r_s = scale_fn(p1r_r, scl_r[3]);
    assign q1i_s = scale_fn(p1i_r, scl_r[3]);
    assign q2r_s = scale_fn(p2r_r, scl_r[3]);
    assign q2i_s = scale_fn(p2i_r, scl_r[3]);
    assign ovf_s = out_of_range(q1r_s) | out_of_range(q1i_s) |
                   out_of_range(q2r_s) | out_of_range(q2i_s);
    // A presented overflow also counts as a set, so a clear in that cycle cannot drop it.
    assign ovf_set_s = (vld_r[3] & ovf_s) | ovf_out;

    // Output registers hold between valid samples; sticky flag gives set priority over clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y1_r <= '0; y1_i <= '0; y2_r <= '0; y2_i <= '0;
            vld_out <= 1'b0; ovf_out <= 1'b0; overflow <= 1'b0;
        end else begin
            vld_out <= vld_r[3];
            if (vld_r[3]) begin
                y1_r    <= fit(q1r_s);
                y1_i    <= fit(q1i_s);
                y2_r    <= fit(q2r_s);
                y2_i    <= fit(q2i_s);
                ovf_out <= ovf_s;
            end else begin
                ovf_out <= 1'b0;
            end
            if (ovf_set_s)    overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            else              overflow <= overflow;
        end
    end

endmodule

// File: tb/tb_fix_butterfly_r2p.sv
// Bench for fix_butterfly_r2p: DIT and DIF instances share stimulus, checked against an arithmetic model.
module tb_fix_butterfly_r2p;
    localparam int W = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, en, inv, scale, ovf_clr;
    logic signed [W-1:0] x1_r, x1_i, x2_r, x2_i, cos_v, sin_v;
    logic signed [W-1:0] y1r [2];
    logic signed [W-1:0] y1i [2];
    logic signed [W-1:0] y2r [2];
    logic signed [W-1:0] y2i [2];
    logic vld [2];
    logic ovo [2];
    logic ovs [2];

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic            v;
        logic [1:0]      ovf;
        logic [7:0][63:0] y;
    } ent_t;

    ent_t   pipe_q[$];
    longint m_y [8];
    bit     m_vld;
    bit     m_ovo [2];
    bit     m_ovs [2];

    fix_butterfly_r2p #(.MODE(0)) u_dit (
        .clk(clk), .rstn(rstn), .en(en),
        .x1_r(x1_r), .x1_i(x1_i), .x2_r(x2_r), .x2_i(x2_i),
        .cosValue(cos_v), .sinValue(sin_v), .inv(inv), .scale(scale), .ovf_clr(ovf_clr),
        .y1_r(y1r[0]), .y1_i(y1i[0]), .y2_r(y2r[0]), .y2_i(y2i[0]),
        .vld_out(vld[0]), .ovf_out(ovo[0]), .overflow(ovs[0])
    );

    fix_butterfly_r2p #(.MODE(1)) u_dif (
        .clk(clk), .rstn(rstn), .en(en),
        .x1_r(x1_r), .x1_i(x1_i), .x2_r(x2_r), .x2_i(x2_i),
        .cosValue(cos_v), .sinValue(sin_v), .inv(inv), .scale(scale), .ovf_clr(ovf_clr),
        .y1_r(y1r[1]), .y1_i(y1i[1]), .y2_r(y2r[1]), .y2_i(y2i[1]),
        .vld_out(vld[1]), .ovf_out(ovo[1]), .overflow(ovs[1])
    );

    function automatic longint rnd_tw(longint p);
        return (p + 64'sd131072) >>> 18;
    endfunction

    function automatic longint fit(longint v, bit scl, inout bit o);
        longint t;
        t = scl ? ((v + 64'sd1) >>> 1) : v;
        if (t > 64'sd524287 || t < -64'sd524288) o = 1'b1;
`ifdef FIX_BF_SAT_EN
        if (t > 64'sd524287) t = 64'sd524287;
        else if (t < -64'sd524288) t = -64'sd524288;
`else
        t = t & 64'sh00000000000FFFFF;
        if (t >= 64'sd524288) t = t - 64'sd1048576;
`endif
        return t;
    endfunction

    // Expected result for the inputs currently driven, both structures
    function automatic ent_t model(bit valid);
        ent_t e;
        longint a_r, a_i, b_r, b_i, c, s, sg, t_r, t_i, d_r, d_i;
        bit o;
        e = '0;
        e.v = valid;
        a_r = longint'(x1_r); a_i = longint'(x1_i);
        b_r = longint'(x2_r); b_i = longint'(x2_i);
        c = longint'(cos_v); s = longint'(sin_v);
        sg = inv ? -64'sd1 : 64'sd1;
        t_r = rnd_tw(b_r * c + sg * b_i * s);
        t_i = rnd_tw(b_i * c - sg * b_r * s);
        o = 1'b0;
        e.y[0] = fit(a_r + t_r, scale, o);
        e.y[1] = fit(a_i + t_i, scale, o);
        e.y[2] = fit(a_r - t_r, scale, o);
        e.y[3] = fit(a_i - t_i, scale, o);
        e.ovf[0] = o;
        d_r = a_r - b_r; d_i = a_i - b_i;
        o = 1'b0;
        e.y[4] = fit(a_r + b_r, scale, o);
        e.y[5] = fit(a_i + b_i, scale, o);
        e.y[6] = fit(rnd_tw(d_r * c + sg * d_i * s), scale, o);
        e.y[7] = fit(rnd_tw(d_i * c - sg * d_r * s), scale, o);
        e.ovf[1] = o;
        return e;
    endfunction

    task automatic chk(string tag, longint obs, longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d_vld_out", m), 64'(vld[m]), 64'(m_vld));
            chk($sformatf("m%0d_y1_r", m), longint'(y1r[m]), m_y[m*4+0]);
            chk($sformatf("m%0d_y1_i", m), longint'(y1i[m]), m_y[m*4+1]);
            chk($sformatf("m%0d_y2_r", m), longint'(y2r[m]), m_y[m*4+2]);
            chk($sformatf("m%0d_y2_i", m), longint'(y2i[m]), m_y[m*4+3]);
            chk($sformatf("m%0d_ovf_out", m), 64'(ovo[m]), 64'(m_ovo[m]));
            chk($sformatf("m%0d_overflow", m), 64'(ovs[m]), 64'(m_ovs[m]));
        end
    endtask

    task automatic reset_model();
        ent_t z;
        z = '0;
        pipe_q.delete();
        repeat (4) pipe_q.push_back(z);
        for (int k = 0; k < 8; k++) m_y[k] = 64'sd0;
        m_vld = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_ovo[m] = 1'b0;
            m_ovs[m] = 1'b0;
        end
    endtask

    // One clock edge: queue expectation for current inputs, retire the one due now, compare
    task automatic tick();
        ent_t e, o;
        bit set;
        e = model(en);
        pipe_q.push_back(e);
        @(posedge clk);
        o = pipe_q.pop_front();
        for (int m = 0; m < 2; m++) begin
            set = m_ovo[m] | (o.v & o.ovf[m]);
            if (o.v) begin
                for (int k = 0; k < 4; k++) m_y[m*4+k] = $signed(o.y[m*4+k]);
                m_ovo[m] = o.ovf[m];
            end else begin
                m_ovo[m] = 1'b0;
            end
            if (set) m_ovs[m] = 1'b1;
            else if (ovf_clr) m_ovs[m] = 1'b0;
        end
        m_vld = o.v;
        #1;
        check_all();
    endtask

    task automatic set_in(int a_r, int a_i, int b_r, int b_i, int c, int s, bit iv, bit sc);
        x1_r = W'(a_r); x1_i = W'(a_i); x2_r = W'(b_r); x2_i = W'(b_i);
        cos_v = W'(c); sin_v = W'(s); inv = iv; scale = sc;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; ovf_clr = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rstn = 1'b1;

        // 1: single sample, W=1, output exactly four edges later
        set_in(512, 0, 256, 0, 262144, 0, 1'b0, 1'b0);
        en = 1'b1; tick(); en = 1'b0;
        repeat (3) tick();
        chk("t1_no_early_vld", 64'(vld[0]), 64'd0);
        tick();
        chk("t1_vld", 64'(vld[0]), 64'd1);
        chk("t1_dit_y1_r", longint'(y1r[0]), 64'sd768);
        chk("t1_dit_y2_r", longint'(y2r[0]), 64'sd256);
        chk("t1_dif_y1_r", longint'(y1r[1]), 64'sd768);
        chk("t1_dif_y2_r", longint'(y2r[1]), 64'sd256);
        tick();

        // 2: W=-j forward then inverse on consecutive cycles
        set_in(0, 0, 256, 0, 0, 262144, 1'b0, 1'b0);
        en = 1'b1; tick();
        inv = 1'b1; tick(); en = 1'b0;
        repeat (3) tick();
        chk("t2_fwd_y1_i", longint'(y1i[0]), -64'sd256);
        chk("t2_fwd_y2_i", longint'(y2i[0]), 64'sd256);
        tick();
        chk("t2_inv_y1_i", longint'(y1i[0]), 64'sd256);
        chk("t2_inv_y2_i", longint'(y2i[0]), -64'sd256);
        tick();

        // 3: overflow without scaling, in range with scaling
        set_in(400000, 0, 400000, 0, 262144, 0, 1'b0, 1'b0);
        en = 1'b1; tick();
        scale = 1'b1; tick(); en = 1'b0;
        repeat (3) tick();
`ifdef FIX_BF_SAT_EN
        chk("t3_y1_r_sat", longint'(y1r[0]), 64'sd524287);
`else
        chk("t3_y1_r_wrap", longint'(y1r[0]), -64'sd248576);
`endif
        chk("t3_ovf_out", 64'(ovo[0]), 64'd1);
        chk("t3_overflow", 64'(ovs[0]), 64'd1);
        tick();
        chk("t3_scaled_y1_r", longint'(y1r[0]), 64'sd400000);
        chk("t3_scaled_ovf_out", 64'(ovo[0]), 64'd0);

        // 4: eight back-to-back samples, then clear of the sticky flag
        for (int i = 0; i < 8; i++) begin
            set_in(i, 0, 0, 0, 262144, 0, 1'b0, 1'b0);
            en = 1'b1;
            tick();
        end
        en = 1'b0;
        repeat (4) tick();
        chk("t4_last_y2_r", longint'(y2r[0]), 64'sd7);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t4_overflow_cleared", 64'(ovs[0]), 64'd0);

        // 5: clear coinciding with a presented overflow loses to the set
        set_in(400000, 0, 400000, 0, 262144, 0, 1'b0, 1'b0);
        en = 1'b1; tick(); en = 1'b0;
        repeat (3) tick();
        ovf_clr = 1'b1; tick();
        chk("t5_overflow_held", 64'(ovs[0]), 64'd1);
        tick(); ovf_clr = 1'b0;
        tick();

        // 6: reset discards an in-flight sample
        set_in(512, 0, 256, 0, 262144, 0, 1'b0, 1'b0);
        en = 1'b1; tick(); en = 1'b0;
        tick();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        reset_model();
        check_all();
        rstn = 1'b1;
        repeat (6) tick();
        en = 1'b1; tick(); en = 1'b0;
        repeat (4) tick();
        chk("t6_dif_y1_r", longint'(y1r[1]), 64'sd768);
        chk("t6_dif_y2_r", longint'(y2r[1]), 64'sd256);

        // Random traffic: full-range data, |cos|,|sin| <= 0.5, random gaps and clears
        for (int n = 0; n < 200; n++) begin
            set_in(int'($urandom_range(0, 1048575)) - 524288,
                   int'($urandom_range(0, 1048575)) - 524288,
                   int'($urandom_range(0, 1048575)) - 524288,
                   int'($urandom_range(0, 1048575)) - 524288,
                   int'($urandom_range(0, 262143)) - 131072,
                   int'($urandom_range(0, 262143)) - 131072,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            en = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            tick();
        end
        en = 1'b0; ovf_clr = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
